// File: rtl/masked_sbox_layer_if.sv
// masked_sbox_layer_if: handshake and share bus of the masked PRINCE S-box layer.
// master drives the input beat and out_ready; slave is the S-box layer itself.
// Optional feature: PRINCE_SBOX_INV_EN adds the per-beat inv select.
interface masked_sbox_layer_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_sh0;
    logic [W-1:0] in_sh1;
    logic [W-1:0] rnd;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sh0;
    logic [W-1:0] out_sh1;
`ifdef PRINCE_SBOX_INV_EN
    logic         inv;

    modport master (
        output in_valid, in_sh0, in_sh1, rnd, out_ready, inv,
        input  in_ready, out_valid, out_sh0, out_sh1
    );

    modport slave (
        input  in_valid, in_sh0, in_sh1, rnd, out_ready, inv,
        output in_ready, out_valid, out_sh0, out_sh1
    );
`else
    modport master (
        output in_valid, in_sh0, in_sh1, rnd, out_ready,
        input  in_ready, out_valid, out_sh0, out_sh1
    );

    modport slave (
        input  in_valid, in_sh0, in_sh1, rnd, out_ready,
        output in_ready, out_valid, out_sh0, out_sh1
    );
`endif
endinterface

// File: rtl/masked_sbox_layer.sv
// masked_sbox_layer: NUM_SBOX first-order 2-share masked PRINCE S-boxes in parallel.
// Stage 1 registers 32 non-complete component terms per S-box; stage 2 XOR-compresses
// them into the two output shares and optionally refreshes both shares with rnd.
// Optional feature: define PRINCE_SBOX_INV_EN to add bus.inv selecting the inverse S-box.
//
// Component terms: each output bit is split into 8 buckets k. Bucket k picks one share
// per input bit: bit1<-k[0], bit2<-k[1], bit3<-k[2], bit0<-parity(k). Every cross product
// of an ANF monomial (degree <= 3) is owned by the lowest bucket whose share choice
// matches it, so each term sees at most one share of every input bit. Buckets 0-3 form
// output share 0, buckets 4-7 output share 1.
module masked_sbox_layer #(
    parameter int NUM_SBOX = 16,
    parameter int REFRESH  = 1
) (
    input logic                clk,
    input logic                rst_n,
    masked_sbox_layer_if.slave bus
);
    localparam int W  = 4 * NUM_SBOX;
    localparam int TW = 32 * NUM_SBOX;

    // Nibble x of each table sits at [4x+3:4x].
    localparam logic [63:0] SBOX_FWD = 64'h4D5E_0876_19CA_23FB;
    localparam logic [63:0] SBOX_INV = 64'h1CE5_046A_98DF_237B;

    function automatic logic [3:0] bucket_sel(input logic [2:0] k);
        return {k[2], k[1], k[0], ^k};
    endfunction

    function automatic logic sbox_bit(input logic inv, input logic [3:0] x, input logic [1:0] b);
        logic [63:0] tbl;
        tbl = inv ? SBOX_INV : SBOX_FWD;
        return tbl[{x, b}];
    endfunction

    // Value of component term k of output bit b; ANF coefficients fold to constants.
    function automatic logic term_value(input logic inv, input logic [1:0] b, input logic [2:0] k,
                                        input logic [3:0] sh0, input logic [3:0] sh1);
        logic [3:0] sel;
        logic [3:0] y;
        logic [3:0] m;
        logic [3:0] x;
        logic       coef;
        logic       own;
        logic       acc;
        sel = bucket_sel(k);
        y   = (sh0 & ~sel) | (sh1 & sel);
        acc = 1'b0;
        for (int mi = 0; mi < 16; mi++) begin
            m    = 4'(mi);
            coef = 1'b0;
            for (int xi = 0; xi < 16; xi++) begin
                x = 4'(xi);
                if ((x & ~m) == 4'b0000) begin
                    coef = coef ^ sbox_bit(inv, x, b);
                end
            end
            own = 1'b1;
            for (int kp = 0; kp < 8; kp++) begin
                if ((3'(kp) < k) && (((bucket_sel(3'(kp)) ^ sel) & m) == 4'b0000)) begin
                    own = 1'b0;
                end
            end
            acc = acc ^ (coef & own & (&(y | ~m)));
        end
        return acc;
    endfunction

    logic          s1_valid;
    logic          s2_valid;
    logic          en1;
    logic          en2;
    logic          accept;
    logic [TW-1:0] term_next;
    logic [TW-1:0] s1_terms;
    logic [W-1:0]  c0;
    logic [W-1:0]  c1;
    logic [W-1:0]  mask;
    logic [W-1:0]  sh0_q;
    logic [W-1:0]  sh1_q;

    assign en2          = !s2_valid | bus.out_ready;
    assign en1          = !s1_valid | en2;
    assign bus.in_ready = en1 & rst_n;
    assign accept       = bus.in_valid & bus.in_ready;

    for (genvar n = 0; n < NUM_SBOX; n++) begin : g_sbox
        for (genvar b = 0; b < 4; b++) begin : g_bit
            for (genvar k = 0; k < 8; k++) begin : g_term
`ifdef PRINCE_SBOX_INV_EN
                assign term_next[32*n + 8*b + k] = bus.inv
                    ? term_value(1'b1, 2'(b), 3'(k), bus.in_sh0[4*n +: 4], bus.in_sh1[4*n +: 4])
                    : term_value(1'b0, 2'(b), 3'(k), bus.in_sh0[4*n +: 4], bus.in_sh1[4*n +: 4]);
`else
                assign term_next[32*n + 8*b + k] =
                    term_value(1'b0, 2'(b), 3'(k), bus.in_sh0[4*n +: 4], bus.in_sh1[4*n +: 4]);
`endif
            end
            assign c0[4*n + b] = ^s1_terms[32*n + 8*b     +: 4];
            assign c1[4*n + b] = ^s1_terms[32*n + 8*b + 4 +: 4];
        end
    end

    if (REFRESH != 0) begin : g_refresh
        assign mask = bus.rnd;
    end else begin : g_no_refresh
        assign mask = '0;
    end

    // Stage 1: capture the component terms of the incoming beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_terms <= '0;
        end else if (en1) begin
            s1_valid <= accept;
            s1_terms <= term_next;
        end
    end

    // Stage 2: compress terms into output shares and apply the fresh mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            sh0_q    <= '0;
            sh1_q    <= '0;
        end else if (en2) begin
            s2_valid <= s1_valid;
            sh0_q    <= c0 ^ mask;
            sh1_q    <= c1 ^ mask;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_sh0   = sh0_q;
    assign bus.out_sh1   = sh1_q;
endmodule

// File: tb/tb_masked_sbox_layer.sv
// tb_masked_sbox_layer: directed self-checking bench for masked_sbox_layer.
// Optional feature: PRINCE_SBOX_INV_EN enables the inverse S-box scenario.
module tb_masked_sbox_layer;
    localparam int W = 64;

    localparam logic [63:0] VEC_X [5] = '{
        64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0000000000000000,
        64'hFFFFFFFFFFFFFFFF, 64'hBF32AC916780E5D4
    };
    localparam logic [63:0] VEC_S [5] = '{
        64'hBF32AC916780E5D4, 64'h4D5E087619CA23FB, 64'hBBBBBBBBBBBBBBBB,
        64'h4444444444444444, 64'h04238E7F916BDC5A
    };

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    masked_sbox_layer_if #(.W(W)) bus ();

    masked_sbox_layer #(.NUM_SBOX(16), .REFRESH(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_sh0    = '0;
        bus.in_sh1    = '0;
        bus.rnd       = '0;
        bus.out_ready = 1'b1;
`ifdef PRINCE_SBOX_INV_EN
        bus.inv       = 1'b0;
`endif
    endtask

    task automatic drive_beat(input logic [63:0] x);
        logic [63:0] m;
        m          = rand64();
        bus.in_sh0 = x ^ m;
        bus.in_sh1 = m;
        bus.rnd    = rand64();
        bus.in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        vectors++;
        if (bus.out_sh0 !== 64'h0) begin
            miscompares++; $display("[TB] FAIL reset_out_sh0: got %h want 0", bus.out_sh0);
        end
        vectors++;
        if (bus.out_sh1 !== 64'h0) begin
            miscompares++; $display("[TB] FAIL reset_out_sh1: got %h want 0", bus.out_sh1);
        end
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL release_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_unmasked();
        @(negedge clk);
        bus.in_sh0 = VEC_X[0]; bus.in_sh1 = '0; bus.rnd = '0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL unmasked_in_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL unmasked_latency1: got out_valid %b want 0", bus.out_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL unmasked_latency2: got out_valid %b want 1", bus.out_valid);
        end
        vectors++;
        if ((bus.out_sh0 ^ bus.out_sh1) !== VEC_S[0]) begin
            miscompares++;
            $display("[TB] FAIL unmasked_value: got %h want %h", bus.out_sh0 ^ bus.out_sh1, VEC_S[0]);
        end
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL unmasked_single: got out_valid %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_masking(input int num);
        logic [63:0] exp_q[$];
        logic [63:0] e;
        int sent = 0;
        int got  = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < num + 20 && got < num; cyc++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("[TB] FAIL masking_extra: got beat %h want none", bus.out_sh0 ^ bus.out_sh1);
                end else begin
                    e = exp_q.pop_front();
                    if ((bus.out_sh0 ^ bus.out_sh1) !== e) begin
                        miscompares++;
                        $display("[TB] FAIL masking_value beat %0d: got %h want %h", got, bus.out_sh0 ^ bus.out_sh1, e);
                    end
                end
                got++;
            end
            if (sent < num) begin
                drive_beat(VEC_X[sent % 5]);
                #1;
                if (bus.in_ready === 1'b1) begin
                    exp_q.push_back(VEC_S[sent % 5]);
                    sent++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (got != num) begin
            miscompares++; $display("[TB] FAIL masking_count: got %0d want %0d", got, num);
        end
    endtask

    task automatic test_refresh();
        logic [63:0] m;
        logic [63:0] r;
        logic [63:0] o0a;
        logic [63:0] o1a;
        m = rand64();
        r = rand64();
        @(negedge clk);
        bus.in_sh0 = VEC_X[1] ^ m; bus.in_sh1 = m; bus.rnd = rand64(); bus.in_valid = 1'b1;
        @(negedge clk);
        bus.rnd = '0;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.rnd = r;
        o0a = bus.out_sh0; o1a = bus.out_sh1;
        vectors++;
        if (bus.out_valid !== 1'b1 || (o0a ^ o1a) !== VEC_S[1]) begin
            miscompares++; $display("[TB] FAIL refresh_first: got valid %b value %h want 1 %h", bus.out_valid, o0a ^ o1a, VEC_S[1]);
        end
        @(negedge clk);
        bus.rnd = rand64();
        vectors++;
        if (bus.out_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL refresh_second_valid: got %b want 1", bus.out_valid);
        end
        vectors++;
        if ((bus.out_sh0 ^ o0a) !== r) begin
            miscompares++; $display("[TB] FAIL refresh_sh0: got %h want %h", bus.out_sh0 ^ o0a, r);
        end
        vectors++;
        if ((bus.out_sh1 ^ o1a) !== r) begin
            miscompares++; $display("[TB] FAIL refresh_sh1: got %h want %h", bus.out_sh1 ^ o1a, r);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_q[$];
        logic [63:0] e;
        logic [63:0] held0;
        int sent = 0;
        int got  = 0;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 6);
            if (sent < 3) drive_beat(VEC_X[sent]);
            else bus.in_valid = 1'b0;
            #1;
            if (cyc >= 2 && cyc < 6) begin
                vectors++;
                if (bus.in_ready !== 1'b0) begin
                    miscompares++; $display("[TB] FAIL stall_in_ready cyc %0d: got %b want 0", cyc, bus.in_ready);
                end
                vectors++;
                if (bus.out_valid !== 1'b1 || (bus.out_sh0 ^ bus.out_sh1) !== VEC_S[0]) begin
                    miscompares++;
                    $display("[TB] FAIL stall_hold cyc %0d: got %b %h want 1 %h", cyc, bus.out_valid, bus.out_sh0 ^ bus.out_sh1, VEC_S[0]);
                end
                if (cyc == 2) held0 = bus.out_sh0;
                else begin
                    vectors++;
                    if (bus.out_sh0 !== held0) begin
                        miscompares++; $display("[TB] FAIL stall_stable cyc %0d: got %h want %h", cyc, bus.out_sh0, held0);
                    end
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                vectors++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
                if ((bus.out_sh0 ^ bus.out_sh1) !== e) begin
                    miscompares++; $display("[TB] FAIL backpressure_order beat %0d: got %h want %h", got, bus.out_sh0 ^ bus.out_sh1, e);
                end
                got++;
            end
            if (sent < 3 && bus.in_ready === 1'b1) begin
                exp_q.push_back(VEC_S[sent]);
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        vectors++;
        if (got != 3) begin
            miscompares++; $display("[TB] FAIL backpressure_count: got %0d want 3", got);
        end
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL backpressure_dup: got out_valid %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        int got = 0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_beat(VEC_X[1]);
        @(negedge clk);
        drive_beat(VEC_X[2]);
        @(negedge clk);
        drive_beat(VEC_X[3]);
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midreset_full: got in_ready %b want 0", bus.in_ready);
        end
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midreset_out_valid: got %b want 0", bus.out_valid);
        end
        vectors++;
        if (bus.out_sh0 !== 64'h0 || bus.out_sh1 !== 64'h0) begin
            miscompares++; $display("[TB] FAIL midreset_shares: got %h %h want 0 0", bus.out_sh0, bus.out_sh1);
        end
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midreset_in_ready_low: got %b want 0", bus.in_ready);
        end
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive_beat(VEC_X[4]);
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL midreset_in_ready_release: got %b want 1", bus.in_ready);
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid === 1'b1) begin
                vectors++;
                if ((bus.out_sh0 ^ bus.out_sh1) !== VEC_S[4]) begin
                    miscompares++; $display("[TB] FAIL midreset_new_beat: got %h want %h", bus.out_sh0 ^ bus.out_sh1, VEC_S[4]);
                end
                got++;
            end
        end
        vectors++;
        if (got != 1) begin
            miscompares++; $display("[TB] FAIL midreset_count: got %0d want 1", got);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got  = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                vectors++;
                if (cyc != got + 2 || (bus.out_sh0 ^ bus.out_sh1) !== VEC_S[got % 5]) begin
                    miscompares++;
                    $display("[TB] FAIL throughput beat %0d: got cyc %0d %h want cyc %0d %h", got, cyc, bus.out_sh0 ^ bus.out_sh1, got + 2, VEC_S[got % 5]);
                end
                got++;
            end
            if (sent < 20) begin
                drive_beat(VEC_X[sent % 5]);
                #1;
                vectors++;
                if (bus.in_ready !== 1'b1) begin
                    miscompares++; $display("[TB] FAIL throughput_in_ready cyc %0d: got %b want 1", cyc, bus.in_ready);
                end else begin
                    sent++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        vectors++;
        if (got != 20) begin
            miscompares++; $display("[TB] FAIL throughput_count: got %0d want 20", got);
        end
    endtask

`ifdef PRINCE_SBOX_INV_EN
    task automatic test_inverse();
        logic [63:0] e;
        int sent = 0;
        int got  = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                e = (got % 2 == 0) ? VEC_X[0] : VEC_S[4];
                vectors++;
                if ((bus.out_sh0 ^ bus.out_sh1) !== e) begin
                    miscompares++; $display("[TB] FAIL inverse beat %0d: got %h want %h", got, bus.out_sh0 ^ bus.out_sh1, e);
                end
                got++;
            end
            if (sent < 6) begin
                bus.in_sh0 = VEC_S[0]; bus.in_sh1 = '0; bus.rnd = rand64();
                bus.inv = (sent % 2 == 0); bus.in_valid = 1'b1;
                sent++;
            end else begin
                bus.in_valid = 1'b0; bus.inv = 1'b0;
            end
        end
        vectors++;
        if (got != 6) begin
            miscompares++; $display("[TB] FAIL inverse_count: got %0d want 6", got);
        end
    endtask
`endif

    // Bound the whole run so a stuck handshake still ends with a report.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_unmasked();
        test_masking(1000);
        test_refresh();
        test_backpressure();
        test_reset_midstream();
        test_back_to_back();
`ifdef PRINCE_SBOX_INV_EN
        test_inverse();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
